// File: rtl/pkmc_wb_wrbuf_pkg.sv
// Shared widths, FIFO entry layout and master FSM encoding for the PKMC
// posted-write buffer.
package pkmc_wb_wrbuf_pkg;

    localparam int ADDR_I_WIDTH = 32;
    localparam int DAT_I_WIDTH  = 32;
    localparam int SEL_I_WIDTH  = 4;

    // Entry layout: {pad[1:0], addr[31:2], dat[31:0], sel[3:0]}
    localparam int ENTRY_WIDTH  = 68;
    localparam int ENT_SEL_LSB  = 0;
    localparam int ENT_DAT_LSB  = ENT_SEL_LSB + SEL_I_WIDTH;
    localparam int ENT_ADDR_LSB = ENT_DAT_LSB + DAT_I_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } wb_state_t;

    function automatic logic [ENTRY_WIDTH-1:0] pack_entry(
        input logic [ADDR_I_WIDTH-3:0] addr_word,
        input logic [DAT_I_WIDTH-1:0]  dat,
        input logic [SEL_I_WIDTH-1:0]  sel
    );
        return {2'b00, addr_word, dat, sel};
    endfunction

endpackage

// File: rtl/pkmc_wb_wrbuf_fifo.sv
// Synchronous write-queue FIFO; only the pointers and count are reset, the
// storage array is not.
module pkmc_wrbuf_fifo #(
    parameter int WIDTH      = 68,
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr <= {DEPTH_LOG2{1'b0}};
            r_count  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_FULL);
    assign empty = (r_count == {(DEPTH_LOG2+1){1'b0}});

endmodule

// File: rtl/pkmc_wb_wrbuf.sv
// Posted-write buffer in front of the PKMC memory controller: writes are acked
// at once and drained in order; reads wait until the queue has emptied.
module pkmc_wb_wrbuf
    import pkmc_wb_wrbuf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_dat_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic        s_rty_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        wr_err_o,
    input  logic        wr_err_clr_i,
    output logic        fifo_empty_o
);

    wb_state_t              r_state;
    wb_state_t              w_state_nxt;
    logic                   w_load_wr;
    logic                   w_load_rd;
    logic                   w_m_clear;

    logic                   w_s_wr_req;
    logic                   w_s_rd_req;
    logic                   w_m_done;
    logic                   w_fifo_push;
    logic                   w_fifo_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [DEPTH_LOG2:0]    w_fifo_count;
    logic [ENTRY_WIDTH-1:0] w_fifo_din;
    logic [ENTRY_WIDTH-1:0] w_fifo_dout;

    logic                   r_ack_q;
    logic                   r_wr_err;
    logic                   r_fifo_empty;
    logic [31:0]            r_m_addr;
    logic [31:0]            r_m_dat;
    logic [3:0]             r_m_sel;
    logic                   r_m_we;
    logic                   r_m_cyc;

    assign w_s_wr_req  = s_cyc_i & s_stb_i & s_we_i;
    assign w_s_rd_req  = s_cyc_i & s_stb_i & ~s_we_i;
    assign w_m_done    = m_ack_i | m_err_i;
    assign w_fifo_pop  = (r_state == ST_WR) & w_m_done;
    // A slot freed by this cycle's pop can be refilled in the same cycle
    assign w_fifo_push = w_s_wr_req & ~r_ack_q & (~w_fifo_full | w_fifo_pop);
    assign w_fifo_din  = pack_entry(s_addr_i[31:2], s_dat_i, s_sel_i);

    pkmc_wrbuf_fifo #(
        .WIDTH      (ENTRY_WIDTH),
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Master FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Master FSM next state; queued writes always win over a pending read
    always_comb begin
        w_state_nxt = r_state;
        w_load_wr   = 1'b0;
        w_load_rd   = 1'b0;
        w_m_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = ST_WR;
                    w_load_wr   = 1'b1;
                end else if (w_s_rd_req) begin
                    w_state_nxt = ST_RD;
                    w_load_rd   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR, ST_RD: begin
                if (w_m_done) begin
                    w_state_nxt = ST_IDLE;
                    w_m_clear   = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_m_clear   = 1'b1;
            end
        endcase
    end

    // Registered master-port signals
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_m_addr <= 32'h0000_0000;
            r_m_dat  <= 32'h0000_0000;
            r_m_sel  <= 4'h0;
            r_m_we   <= 1'b0;
            r_m_cyc  <= 1'b0;
        end else if (w_load_wr) begin
            r_m_addr <= {w_fifo_dout[ENT_ADDR_LSB +: 30], 2'b00};
            r_m_dat  <= w_fifo_dout[ENT_DAT_LSB +: 32];
            r_m_sel  <= w_fifo_dout[ENT_SEL_LSB +: 4];
            r_m_we   <= 1'b1;
            r_m_cyc  <= 1'b1;
        end else if (w_load_rd) begin
            r_m_addr <= {s_addr_i[31:2], 2'b00};
            r_m_dat  <= 32'h0000_0000;
            r_m_sel  <= s_sel_i;
            r_m_we   <= 1'b0;
            r_m_cyc  <= 1'b1;
        end else if (w_m_clear) begin
            r_m_we   <= 1'b0;
            r_m_cyc  <= 1'b0;
        end
    end

    // Write ack pulse, sticky write error and registered empty flag
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ack_q      <= 1'b0;
            r_wr_err     <= 1'b0;
            r_fifo_empty <= 1'b1;
        end else begin
            r_ack_q      <= w_fifo_push;
            r_fifo_empty <= (w_fifo_count == {(DEPTH_LOG2+1){1'b0}});
            if ((r_state == ST_WR) && m_err_i) begin
                r_wr_err <= 1'b1;
            end else if (wr_err_clr_i) begin
                r_wr_err <= 1'b0;
            end
        end
    end

    // Read responses pass straight through; dropped by an abandoned slave cycle
    assign s_ack_o      = r_ack_q | ((r_state == ST_RD) & m_ack_i & w_s_rd_req);
    assign s_err_o      = (r_state == ST_RD) & m_err_i & w_s_rd_req;
    assign s_dat_o      = m_dat_i;
    assign s_rty_o      = 1'b0;

    assign m_addr_o     = r_m_addr;
    assign m_dat_o      = r_m_dat;
    assign m_sel_o      = r_m_sel;
    assign m_we_o       = r_m_we;
    assign m_cyc_o      = r_m_cyc;
    assign m_stb_o      = r_m_cyc;
    assign wr_err_o     = r_wr_err;
    assign fifo_empty_o = r_fifo_empty;

endmodule

// File: tb/tb_pkmc_wb_wrbuf.sv
// Randomized bench for pkmc_wb_wrbuf: a bus master and a memory responder
// drive the DUT while a queue-based model predicts every cycle's outputs.
module tb_pkmc_wb_wrbuf;

    localparam int DEPTH = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] s_addr_i, s_dat_i, s_dat_o, m_addr_o, m_dat_o, m_dat_i;
    logic [3:0]  s_sel_i, m_sel_o;
    logic        s_we_i, s_cyc_i, s_stb_i, s_ack_o, s_err_o, s_rty_o;
    logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i;
    logic        wr_err_o, wr_err_clr_i, fifo_empty_o;

    always #5 wb_clk_i = ~wb_clk_i;

    pkmc_wb_wrbuf #(.DEPTH(DEPTH), .DEPTH_LOG2(2)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .s_addr_i(s_addr_i), .s_dat_i(s_dat_i), .s_sel_i(s_sel_i),
        .s_we_i(s_we_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i),
        .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
        .m_addr_o(m_addr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .wr_err_o(wr_err_o), .wr_err_clr_i(wr_err_clr_i), .fifo_empty_o(fifo_empty_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    // Reference model: posted writes not yet retired, and the expected master cycle
    wr_t         wq[$];
    int          mdl_busy;            // 0 none, 1 posted write, 2 read
    logic [31:0] mdl_addr, mdl_dat;
    logic [3:0]  mdl_sel;
    logic        mdl_ack_q, mdl_err, mdl_empty;

    // Bus master operation in progress
    logic        op_act, op_we, hold, no_new_ops;
    logic [31:0] op_addr, op_dat;
    logic [3:0]  op_sel;
    int          wr_pct, ack_pct, err_pct;

    task automatic reset_model();
        wq.delete();
        mdl_busy  = 0;
        mdl_ack_q = 1'b0;
        mdl_err   = 1'b0;
        mdl_empty = 1'b1;
        op_act    = 1'b0;
        hold      = 1'b0;
    endtask

    task automatic drive_idle();
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        s_addr_i = 32'h0; s_dat_i = 32'h0; s_sel_i = 4'h0;
        m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = 32'h0; wr_err_clr_i = 1'b0;
    endtask

    task automatic step();
        logic rd_live, wr_live, pop, rdone, push, exp_sack, exp_serr, empty_nxt;
        int   r;
        wr_t  e;
        @(negedge wb_clk_i);
        if (hold && mdl_busy == 0) hold = 1'b0;
        if (!op_act && !hold && !no_new_ops && $urandom_range(99) < 70) begin
            op_act  = 1'b1;
            op_we   = ($urandom_range(99) < wr_pct);
            op_addr = $urandom();
            op_dat  = $urandom();
            op_sel  = 4'($urandom_range(15, 1));
        end
        if (op_act && !op_we && mdl_busy == 2 && $urandom_range(99) < 3) begin
            op_act = 1'b0;
            hold   = 1'b1;
        end
        s_cyc_i  = op_act;
        s_stb_i  = op_act;
        s_we_i   = op_we;
        s_addr_i = op_act ? op_addr : $urandom();
        s_dat_i  = op_act ? op_dat  : $urandom();
        s_sel_i  = op_sel;
        m_ack_i  = 1'b0;
        m_err_i  = 1'b0;
        m_dat_i  = $urandom();
        if (mdl_busy != 0) begin
            r = $urandom_range(99);
            if (r < err_pct)      m_err_i = 1'b1;
            else if (r < ack_pct) m_ack_i = 1'b1;
        end
        wr_err_clr_i = ($urandom_range(99) < 5);
        #1;
        rd_live  = op_act & ~op_we;
        wr_live  = op_act & op_we;
        pop      = (mdl_busy == 1) & (m_ack_i | m_err_i);
        rdone    = (mdl_busy == 2) & (m_ack_i | m_err_i);
        exp_sack = mdl_ack_q | ((mdl_busy == 2) & m_ack_i & rd_live);
        exp_serr = (mdl_busy == 2) & m_err_i & rd_live;

        check_val("m_cyc", m_cyc_o, mdl_busy != 0);
        check_val("m_stb", m_stb_o, mdl_busy != 0);
        check_val("s_ack", s_ack_o, exp_sack);
        check_val("s_err", s_err_o, exp_serr);
        check_val("s_rty", s_rty_o, 1'b0);
        check_val("s_dat", s_dat_o, m_dat_i);
        check_val("wr_err", wr_err_o, mdl_err);
        check_val("fifo_empty", fifo_empty_o, mdl_empty);
        if (mdl_busy != 0) begin
            check_val("m_we", m_we_o, mdl_busy == 1);
            check_val("m_addr", m_addr_o, mdl_addr);
            check_val("m_sel", m_sel_o, mdl_sel);
            if (mdl_busy == 1) check_val("m_dat", m_dat_o, mdl_dat);
        end

        // Advance the model across the coming rising edge
        push      = wr_live & ~mdl_ack_q & ((wq.size() < DEPTH) | pop);
        empty_nxt = (wq.size() == 0);
        if (pop && m_err_i)   mdl_err = 1'b1;
        else if (wr_err_clr_i) mdl_err = 1'b0;
        if (mdl_busy != 0) begin
            if (pop || rdone) mdl_busy = 0;
        end else if (wq.size() != 0) begin
            mdl_busy = 1;
            mdl_addr = wq[0].addr;
            mdl_dat  = wq[0].dat;
            mdl_sel  = wq[0].sel;
        end else if (rd_live) begin
            mdl_busy = 2;
            mdl_addr = {op_addr[31:2], 2'b00};
            mdl_sel  = op_sel;
        end
        if (pop) void'(wq.pop_front());
        if (push) begin
            e.addr = {op_addr[31:2], 2'b00};
            e.dat  = op_dat;
            e.sel  = op_sel;
            wq.push_back(e);
        end
        mdl_ack_q = push;
        mdl_empty = empty_nxt;
        if (exp_sack || exp_serr) op_act = 1'b0;
    endtask

    task automatic run(input int n, input int wp, input int ap, input int ep);
        wr_pct = wp; ack_pct = ap; err_pct = ep;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        no_new_ops = 1'b0;
        op_we = 1'b0; op_sel = 4'h0; op_addr = 32'h0; op_dat = 32'h0;
        reset_model();
        drive_idle();
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        #1;
        check_val("rst_m_cyc", m_cyc_o, 1'b0);
        check_val("rst_m_stb", m_stb_o, 1'b0);
        check_val("rst_m_we", m_we_o, 1'b0);
        check_val("rst_m_addr", m_addr_o, 32'h0);
        check_val("rst_m_dat", m_dat_o, 32'h0);
        check_val("rst_m_sel", m_sel_o, 4'h0);
        check_val("rst_s_ack", s_ack_o, 1'b0);
        check_val("rst_s_err", s_err_o, 1'b0);
        check_val("rst_wr_err", wr_err_o, 1'b0);
        check_val("rst_fifo_empty", fifo_empty_o, 1'b1);
        wb_rst_i = 1'b1;

        run(1500, 70, 40, 5);
        run(300, 100, 5, 0);
        run(600, 50, 90, 10);

        // Fill the queue with the memory stalled, then reset mid-write
        wr_pct = 100; ack_pct = 0; err_pct = 0;
        for (int i = 0; i < 300 && !(wq.size() >= 3 && mdl_busy == 1); i++) step();
        check_val("midrst_setup", (wq.size() >= 3 && mdl_busy == 1), 1'b1);
        @(negedge wb_clk_i);
        drive_idle();
        wb_rst_i = 1'b0;
        #1;
        check_val("midrst_m_cyc", m_cyc_o, 1'b0);
        check_val("midrst_m_stb", m_stb_o, 1'b0);
        check_val("midrst_fifo_empty", fifo_empty_o, 1'b1);
        check_val("midrst_s_ack", s_ack_o, 1'b0);
        reset_model();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        no_new_ops = 1'b1;
        run(6, 100, 50, 0);
        no_new_ops = 1'b0;
        run(400, 60, 50, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkmc_wb_wrbuf.md
Name: pkmc_wb_wrbuf

Overview:
Posted-write buffer placed directly upstream of the PKMC Wishbone memory controller (SRAM/SDRAM/flash). It acks CPU/bus writes in one cycle, queues them in a small FIFO and retires them to the memory controller in order. Reads drain the queue before being forwarded, which keeps read-after-write ordering intact. Its master port feeds the memory controller's Wishbone slave port unchanged.

Parameters:
DEPTH, 4, FIFO entries; must be a power of two, minimum 2
DEPTH_LOG2, 2, log2(DEPTH); width of the FIFO pointers

Ports:
wb_clk_i  in  1  system clock; all logic on the rising edge
wb_rst_i  in  1  asynchronous, active-low reset
s_addr_i  in  32  slave address; bits [1:0] are ignored and forced to 0 downstream
s_dat_i  in  32  slave write data
s_sel_i  in  4  slave byte selects
s_we_i  in  1  slave write enable
s_cyc_i  in  1  slave cycle
s_stb_i  in  1  slave strobe
s_dat_o  out  32  read data, equal to m_dat_i
s_ack_o  out  1  slave acknowledge
s_err_o  out  1  slave error; read errors only
s_rty_o  out  1  tied 0
m_addr_o  out  32  to memory controller wb_addr_i
m_dat_o  out  32  to memory controller wb_dat_i
m_sel_o  out  4  byte selects to memory controller
m_we_o  out  1  write enable to memory controller
m_cyc_o  out  1  cycle to memory controller
m_stb_o  out  1  strobe to memory controller
m_dat_i  in  32  from memory controller wb_dat_o
m_ack_i  in  1  from memory controller wb_ack_o
m_err_i  in  1  from memory controller wb_err_o
wr_err_o  out  1  sticky: a posted write got m_err_i
wr_err_clr_i  in  1  synchronous clear of wr_err_o
fifo_empty_o  out  1  high when the write queue is empty

Behaviour:
- Reset (wb_rst_i=0, async): FIFO is empty; state is IDLE. All m_* outputs are 0. s_ack_o=0, s_err_o=0, wr_err_o=0, fifo_empty_o=1.
- Write accept, cycle N: s_cyc&s_stb&s_we&!full&!ack_q. The entry {addr[31:2],2'b0; dat; sel} is pushed. s_ack_o is a registered one-cycle pulse in N+1 (ack_q). While full, the write waits with no ack. The write is accepted in the cycle the pop frees a slot.
- Master FSM states: IDLE, WR, RD.
  - IDLE -> WR when the FIFO is not empty. The head entry is registered onto m_*; m_we_o=1, cyc=stb=1.
  - WR: m_* held until m_ack_i|m_err_i. The entry is then popped and cyc/stb drop for one cycle; the next transaction is never issued back-to-back. If m_err_i: wr_err_o<=1, no retry. Next state is IDLE.
  - IDLE -> RD when the FIFO is empty and a slave read is pending (cyc&stb&!we). Address and sel are registered, m_we_o=0.
  - RD: s_ack_o = m_ack_i and s_err_o = m_err_i, combinational pass-through. s_dat_o = m_dat_i. On m_ack_i|m_err_i, cyc/stb are cleared and the state returns to IDLE.
  - A pending read never bypasses queued writes. New writes are not accepted while the slave read is outstanding, because the bus master is stalled.
  - If s_cyc_i drops during RD, the current master cycle still completes and its ack is discarded.
- Simultaneous push and pop in the same cycle: both take effect; the count is unchanged.
- Pointers wrap modulo DEPTH. full/empty use a count width of DEPTH_LOG2+1.
- wr_err_o: a set in the same cycle as wr_err_clr_i wins.
- fifo_empty_o is registered from the count.
- Reset mid-operation aborts the in-flight master cycle. Queued writes are lost.

Decomposition:
- Shared defines (pkmc_memctrl_defines.v): ADDR_I_WIDTH=32, DAT_I_WIDTH=32, SEL_I_WIDTH=4, and the state encodings IDLE=2'd0, WR=2'd1, RD=2'd2.
- Sub-module pkmc_wrbuf_fifo: synchronous FIFO, 68 bits wide (30-bit addr + 32 data + 4 sel, padded), DEPTH entries. Ports: push, pop, din, dout, full, empty, count. Async active-low reset on the pointers only.

Test Plan:
- Single write 0x0000_1004 / 0xDEADBEEF / sel 4'hF -> s_ack_o one cycle later; m_cyc/stb/we=1 with the same values; m_ack_i -> fifo_empty_o=1.
- 5 back-to-back writes, DEPTH=4, m_ack_i held low -> 4 acks; the 5th stalls until the first m_ack_i, then is acked the next cycle. Order out matches order in.
- Write 0x100=0x11 then read 0x100 -> m_* shows the write, then the read (we=0). s_ack_o asserts only with m_ack_i of the read. s_dat_o=m_dat_i=0x11.
- m_err_i on a posted write -> wr_err_o=1 and stays 1; wr_err_clr_i pulse -> 0. The following queued write still issues.
- Read with m_err_i -> s_err_o=1 that cycle, s_ack_o=0, FSM returns to IDLE.
- Assert wb_rst_i=0 mid-WR with 3 entries queued -> m_cyc_o=0 and fifo_empty_o=1 immediately; no m_stb_o after release until a new write arrives.
